// File: rtl/i2s_tx_slave_fmt.sv
// i2s_tx_slave_fmt: slave-clocked audio transmitter with a stereo-frame FIFO.
// Supports left-justified, I2S and right-justified output framing.
module i2s_tx_slave_fmt #(
    parameter int AUDIO_DW   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           sclk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [1:0]                     fmt,
    input  logic [5:0]                     slot_len,
    input  logic                           lrclk,
    output logic                           sdata,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [AUDIO_DW-1:0]            in_left,
    input  logic [AUDIO_DW-1:0]            in_right,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           underrun,
    output logic [15:0]                    underrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2*AUDIO_DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wp, rp, count;
    logic                  lr_d, en_q, lj_prev, lj_bit, rj_bit, in_slot;
    logic [1:0]            fmt_q;
    logic [5:0]            slot_q, k;
    logic [AUDIO_DW-1:0]   hl, hr;
    logic [31:0]           w;
    logic [4:0]            lj_idx, rj_idx;
    logic [6:0]            rj_lo;
    logic                  edge_e, left_start, empty, full, push, pop;

    assign count      = wp - rp;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign in_ready   = !full;
    assign fifo_level = count;
    assign edge_e     = lrclk != lr_d;
    assign left_start = edge_e && !lrclk;
    assign push       = in_valid && !full;
    assign pop        = left_start && en && !empty;

    // lr_d tracks the channel of the slot currently being shifted out
    assign w       = 32'(lr_d ? hr : hl);
    assign lj_idx  = 5'(AUDIO_DW - 1) - k[4:0];
    assign rj_idx  = slot_q[4:0] - 5'd1 - k[4:0];
    assign rj_lo   = {1'b0, slot_q} - 7'(AUDIO_DW);
    assign in_slot = en_q && k < slot_q;
    assign lj_bit  = in_slot && {1'b0, k} < 7'(AUDIO_DW) && w[lj_idx];
    assign rj_bit  = in_slot && {1'b0, k} >= rj_lo && w[rj_idx];
    assign sdata   = fmt_q == 2'b10 ? rj_bit : fmt_q == 2'b01 ? (in_slot && lj_prev) : lj_bit;

    always_ff @(negedge sclk)
        if (push) mem[wp[AW-1:0]] <= {in_left, in_right};

    always_ff @(negedge sclk or posedge rst)
        if (rst) begin
            lr_d         <= 1'b0;
            k            <= '0;
            lj_prev      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            wp           <= '0;
            rp           <= '0;
            en_q         <= 1'b0;
            fmt_q        <= 2'b00;
            slot_q       <= '0;
            hl           <= '0;
            hr           <= '0;
        end else begin
            lr_d     <= lrclk;
            k        <= edge_e ? 6'd0 : (k == 6'd63 ? k : k + 6'd1);
            lj_prev  <= lj_bit;
            underrun <= 1'b0;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (left_start) begin
                en_q   <= en;
                fmt_q  <= fmt;
                slot_q <= slot_len;
                if (pop)
                    {hl, hr} <= mem[rp[AW-1:0]];
                else if (en) begin
                    hl       <= '0;
                    hr       <= '0;
                    underrun <= 1'b1;
                    if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
                end
            end
        end
endmodule

// File: tb/tb_i2s_tx_slave_fmt.sv
// tb_i2s_tx_slave_fmt: scoreboard bench; expected serial bits are queued per frame
// at each left start and compared edge by edge against sdata.
module tb_i2s_tx_slave_fmt;
    localparam int DW = 16, DEPTH = 4;

    logic          sclk = 0, rst = 1, en = 0, lrclk = 0, in_valid = 0;
    logic [1:0]    fmt = 0;
    logic [5:0]    slot_len = 16;
    logic [DW-1:0] in_left = 0, in_right = 0;
    logic          sdata, in_ready, underrun;
    logic [2:0]    fifo_level;
    logic [15:0]   underrun_cnt;

    int          n_vec = 0, n_err = 0, ucnt = 0;
    logic [31:0] fq[$];
    logic        exp_q[$];
    logic        carry = 0;

    always #5 sclk = ~sclk;

    i2s_tx_slave_fmt #(.AUDIO_DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .sclk(sclk), .rst(rst), .en(en), .fmt(fmt), .slot_len(slot_len), .lrclk(lrclk),
        .sdata(sdata), .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left),
        .in_right(in_right), .fifo_level(fifo_level), .underrun(underrun),
        .underrun_cnt(underrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ljb(input logic [DW-1:0] w, input int k, input int s);
        return (k < s && k < DW) ? w[DW-1-k] : 1'b0;
    endfunction

    function automatic logic rjb(input logic [DW-1:0] w, input int k, input int s);
        return (k < s && k >= s - DW) ? w[s-1-k] : 1'b0;
    endfunction

    task automatic step(input logic lr);
        @(posedge sclk);
        lrclk = lr;
        @(negedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(lrclk);
            check("idle_sdata", sdata, 0);
        end
        carry = 0;
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(posedge sclk);
        in_valid = 1;
        in_left  = l;
        in_right = r;
        #1;
        check("in_ready", in_ready, fq.size() < DEPTH);
        @(negedge sclk);
        if (fq.size() < DEPTH) fq.push_back({l, r});
        #1;
        in_valid = 0;
        carry = 0;
    endtask

    task automatic frame(input logic [1:0] f, input int s, input logic e);
        logic [DW-1:0] l = 0, r = 0;
        logic          ur = 0;
        logic [1:0]    fm = (f == 2'b11) ? 2'b00 : f;
        if (e) begin
            if (fq.size() == 0) begin
                ur = 1;
                ucnt++;
            end else {l, r} = fq.pop_front();
        end
        for (int k = 0; k < s; k++)
            exp_q.push_back(!e ? 1'b0 : fm == 2 ? rjb(l, k, s) :
                            fm == 1 ? (k == 0 ? carry : ljb(l, k-1, s)) : ljb(l, k, s));
        for (int k = 0; k < s; k++)
            exp_q.push_back(!e ? 1'b0 : fm == 2 ? rjb(r, k, s) :
                            fm == 1 ? (k == 0 ? ljb(l, s-1, s) : ljb(r, k-1, s)) : ljb(r, k, s));
        carry = e ? ljb(r, s-1, s) : 1'b0;
        fmt = f;
        slot_len = 6'(s);
        en = e;
        for (int i = 0; i < 2*s; i++) begin
            step(i < s ? 1'b0 : 1'b1);
            check("sdata", sdata, exp_q.pop_front());
            if (i == 0) begin
                check("underrun", underrun, ur);
                check("underrun_cnt", underrun_cnt, ucnt);
                check("fifo_level", fifo_level, fq.size());
                check("in_ready_pop", in_ready, fq.size() < DEPTH);
            end
            if (i == 1) check("underrun_pulse", underrun, 0);
            // mid-frame control changes must wait for the next left start
            if (i == 3) begin
                fmt = fmt ^ 2'b01;
                slot_len = 6'd40;
                en = !en;
            end
        end
    endtask

    initial begin
        #1;
        check("rst_sdata", sdata, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_underrun", underrun, 0);
        check("rst_cnt", underrun_cnt, 0);
        #11 rst = 0;
        idle(2);
        lrclk = 1;
        idle(2);

        push(16'hA5F0, 16'h0F3C);
        frame(2'b00, 16, 1);
        push(16'hA5F0, 16'h0F3D);
        push(16'hA5F0, 16'h0F3C);
        frame(2'b01, 16, 1);
        frame(2'b01, 16, 1);
        push(16'h8001, 16'h1234);
        frame(2'b10, 24, 1);
        frame(2'b00, 24, 1);
        frame(2'b11, 16, 1);
        push(16'h1111, 16'h2222);
        frame(2'b00, 16, 0);

        for (int i = 0; i < 4; i++) push(16'(i * 16'h1357 + 1), 16'(i * 16'h2468 + 3));
        check("full_level", fifo_level, DEPTH);
        check("full_ready", in_ready, 0);
        frame(2'b00, 16, 1);

        for (int it = 0; it < 6; it++) begin
            int np = $urandom_range(0, 2);
            for (int j = 0; j < np; j++) push(16'($urandom), 16'($urandom));
            frame(2'($urandom_range(0, 3)), $urandom_range(16, 40), $urandom_range(0, 4) != 0);
        end

        while (fq.size() > 0) frame(2'b00, 16, 1);
        push(16'h1234, 16'hFFFF);
        push(16'h5678, 16'h9ABC);
        fmt = 0;
        slot_len = 16;
        en = 1;
        void'(fq.pop_front());
        for (int i = 0; i < 21; i++) step(i < 16 ? 1'b0 : 1'b1);
        check("pre_rst_sdata", sdata, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_sdata", sdata, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_cnt", underrun_cnt, 0);
        @(posedge sclk);
        #1 rst = 0;
        fq.delete();
        ucnt = 0;
        idle(3);
        push(16'hC3A5, 16'h7E81);
        frame(2'b00, 16, 1);
        frame(2'b01, 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_tx_slave_fmt.md
I2S_TX_SLAVE_FMT -- requirements
Module: i2s_tx_slave_fmt

Interface
REQ-001 SHALL have parameter AUDIO_DW, default 32, sample width in bits (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, stereo-frame FIFO depth (power of two, >=2).
REQ-003 SHALL have port sclk  input  1  bit clock, sole clock, all flops on falling edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port en  input  1  transmit enable.
REQ-006 SHALL have port fmt  input  2  00 left-justified, 01 I2S, 10 right-justified, 11 treated as 00.
REQ-007 SHALL have port slot_len  input  6  sclk cycles per channel slot (AUDIO_DW..63).
REQ-008 SHALL have port lrclk  input  1  external word clock, 0 = left, 1 = right.
REQ-009 SHALL have port sdata  output  1  serial data.
REQ-010 SHALL have port in_valid  input  1  frame offered.
REQ-011 SHALL have port in_ready  output  1  FIFO can accept.
REQ-012 SHALL have ports in_left and in_right  input  AUDIO_DW each  frame samples.
REQ-013 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  frames stored.
REQ-014 SHALL have port underrun  output  1  one-cycle pulse on starved frame.
REQ-015 SHALL have port underrun_cnt  output  16  saturating underrun count.

Function
REQ-016 SHALL register lrclk into lr_d each falling edge; slot start E = edge where lrclk != lr_d; left start if lrclk=0, right start if lrclk=1.
REQ-017 SHALL reset bit counter k to 0 at E and increment it each later edge, saturating at 63.
REQ-018 SHALL push {in_left,in_right} when in_valid && in_ready; in_ready = !full, combinational.
REQ-019 SHALL pop one frame at each left start while en=1 and FIFO non-empty, into left/right holding registers.
REQ-020 SHALL, at left start with en=1 and FIFO empty, load zeros into both holding registers, pulse underrun, and increment underrun_cnt (hold at 0xFFFF).
REQ-021 SHALL give no push-to-pop bypass: a push and a left start on the same edge with FIFO empty is an underrun; the pushed frame is kept.
REQ-022 SHALL, when full, hold in_ready=0 even on a pop edge; space is visible on the following edge.
REQ-023 SHALL latch fmt, slot_len and en only at left start; mid-frame changes take effect at the next left start.
REQ-024 SHALL drive LJ bit k of the active word W at slot edge k: W[AUDIO_DW-1-k] for k<AUDIO_DW, else 0.
REQ-025 SHALL, in I2S mode, drive sdata equal to the LJ stream delayed one sclk, carrying the previous slot's last bit across the boundary.
REQ-026 SHALL, in RJ mode, drive W[slot_len-1-k] for slot_len-AUDIO_DW <= k < slot_len, else 0.
REQ-027 SHALL drive 0 for k >= slot_len in all modes.
REQ-028 SHALL drive sdata=0 from reset until the first left start with latched en=1, and for frames whose latched en=0; no pops or underruns occur while latched en=0.
REQ-029 SHALL keep fifo_level accurate on simultaneous push and pop (unchanged).

Reset
REQ-030 SHALL on rst=1 immediately force sdata=0, underrun=0, underrun_cnt=0, fifo_level=0, in_ready=1, lr_d=0, k=0, holding registers=0, fmt latch=00.
REQ-031 SHALL, when rst asserts mid-slot, discard FIFO contents and the current frame; transmission resumes at the first left start after release.

Verification
REQ-032 SHALL cover LJ, AUDIO_DW=16, slot_len=16, frame L=0xA5F0 R=0x0F3C -> left slot bits 1010010111110000, right slot bits 0000111100111100.
REQ-033 SHALL cover I2S, AUDIO_DW=16, slot_len=16, same frame -> first left-slot bit is previous right LSB, then 0xA5F0 MSB-first one sclk late.
REQ-034 SHALL cover RJ, AUDIO_DW=16, slot_len=24, L=0x8001 -> 8 zeros, then 1000000000000001.
REQ-035 SHALL cover empty FIFO at left start -> underrun one cycle, underrun_cnt 0->1, 48 zero bits for the frame.
REQ-036 SHALL cover FIFO_DEPTH=4, 4 pushes with no lrclk -> fifo_level=4, in_ready=0; one left start -> level 3, in_ready=1 next edge.
REQ-037 SHALL cover rst pulse mid right slot with 2 frames queued -> sdata=0 at once, fifo_level=0, output silent until next left start plus new data.
